// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 TxD,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_reg, state_next;
  logic [BAUD_W-1:0]    baud_reg, baud_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 txd_reg, txd_next;
  logic                 ready_reg, ready_next;
  logic                 busy_reg, busy_next;
  logic                 baud_done;

`ifdef UART_TX_PARITY_EN
  logic parity_reg, parity_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= parity_next;
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
`endif

  assign baud_done = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (tx_valid && ready_reg) begin
          shift_next = tx_data;
          baud_next  = '0;
          bit_next   = '0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          parity_next = (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = STOP;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_reg == STOP_LAST) begin
            bit_next   = '0;
            state_next = IDLE;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is computed from the next state so TxD comes straight from a flop.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = parity_next;
`endif
      default: txd_next = 1'b1;
    endcase
    ready_next = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
  end

  assign tx_ready = ready_reg;
  assign TxD      = txd_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: frame-level model checked every cycle plus literal frame expectations.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_core;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS  = 1 + DB + PB + SB;
  localparam int FLEN   = NBITS * CPB;
  localparam int F5LEN  = (1 + 5 + PB + 2) * CPB;
  localparam int LOGMAX = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, TxD, busy;

  logic v5 = 1'b0;
  logic [4:0] d5 = 5'h00;
  logic rdy5, txd5, busy5;

  logic vd = 1'b0;
  logic [7:0] dd = 8'h00;
  logic rdyd, txdd, busyd;

  int n_cmp = 0;
  int n_bad = 0;

  logic lg_txd [LOGMAX];
  logic lg_busy [LOGMAX];
  logic lg_rdy [LOGMAX];
  logic lg_txd5 [LOGMAX];
  logic lg_busy5 [LOGMAX];
  int lg_n = 0;

  // Frame model: position in the frame in clk cycles (-1 when idle) and the frame's bit list.
  int   m_pos;
  logic m_ready;
  logic m_bits [0:15];

  always #5 clk = ~clk;

  uart_tx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .TxD(TxD), .busy(busy)
  );

  uart_tx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) dut5 (
    .clk(clk), .reset(reset), .tx_valid(v5), .tx_data(d5),
    .tx_ready(rdy5), .TxD(txd5), .busy(busy5)
  );

  uart_tx_core dut_def (
    .clk(clk), .reset(reset), .tx_valid(vd), .tx_data(dd),
    .tx_ready(rdyd), .TxD(txdd), .busy(busyd)
  );

  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= DB) return d[i-1];
    if (PB == 1 && i == DB + 1) return ^d;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos   <= -1;
      m_ready <= 1'b0;
    end else if (m_pos >= 0) begin
      if (m_pos + 1 == FLEN) begin
        m_pos   <= -1;
        m_ready <= 1'b1;
      end else begin
        m_pos <= m_pos + 1;
      end
    end else if (m_ready && tx_valid) begin
      m_pos   <= 0;
      m_ready <= 1'b0;
      for (int i = 0; i < 16; i++) m_bits[i] <= frame_bit(tx_data, i);
    end else begin
      m_ready <= 1'b1;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: compare the main DUT to the model on the falling edge and log all outputs.
  task automatic step();
    logic e_txd;
    @(posedge clk);
    @(negedge clk);
    e_txd = (m_pos < 0) ? 1'b1 : m_bits[m_pos / CPB];
    check("model_txd", TxD, e_txd);
    check("model_busy", busy, (m_pos >= 0));
    check("model_ready", tx_ready, m_ready);
    if (lg_n < LOGMAX) begin
      lg_txd[lg_n]   = TxD;
      lg_busy[lg_n]  = busy;
      lg_rdy[lg_n]   = tx_ready;
      lg_txd5[lg_n]  = txd5;
      lg_busy5[lg_n] = busy5;
      lg_n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:10] exp_a5;
    logic [0:10] exp_3c;
    int cnt;
    int lowc;
`ifdef UART_TX_PARITY_EN
    exp_a5 = 11'b01010010101;
    exp_3c = 11'b00011110001;
`else
    exp_a5 = 11'b01010010110;
    exp_3c = 11'b00011110010;
`endif

    // Reset state
    step();
    check("rst_txd", TxD, 1'b1);
    check("rst_ready", tx_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();
    check("ready_after_rst", tx_ready, 1'b1);

    // 0xA5, data changed right after acceptance
    tx_valid = 1'b1; tx_data = 8'hA5; lg_n = 0;
    step();
    tx_valid = 1'b0; tx_data = 8'hFF;
    repeat (FLEN + 2) step();
    for (int k = 0; k < NBITS; k++)
      check($sformatf("a5_bit%0d", k), lg_txd[k*CPB+2], exp_a5[k]);
    cnt = 0;
    for (int i = 0; i < FLEN + 3; i++) cnt += int'(lg_busy[i]);
    check_int("a5_frame_len", cnt, (PB == 1) ? 44 : 40);
    cnt = 0;
    for (int i = 0; i < FLEN; i++) cnt += int'(lg_rdy[i]);
    check_int("a5_ready_in_frame", cnt, 0);
    check("a5_ready_after", lg_rdy[FLEN], 1'b1);

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07
    tx_valid = 1'b1; tx_data = 8'h07; lg_n = 0;
    step();
    tx_valid = 1'b0;
    repeat (FLEN + 2) step();
    check("p07_even_bit", lg_txd[9*CPB+2], 1'b1);
    cnt = 0;
    for (int i = 0; i < FLEN + 3; i++) cnt += int'(lg_busy[i]);
    check_int("p07_frame_len", cnt, 44);
`endif

    // Back-to-back with tx_valid held: 0x00 then 0xFF
    tx_valid = 1'b1; tx_data = 8'h00; lg_n = 0;
    step();
    tx_data = 8'hFF;
    for (int i = 0; i < 2 * FLEN + 4; i++) begin
      if (i == FLEN + 8) begin
        tx_valid = 1'b0; tx_data = 8'h00;
      end
      step();
    end
    cnt = 0;
    for (int i = 0; i <= 2 * FLEN; i++) cnt += int'(lg_rdy[i]);
    check_int("b2b_ready_cycles", cnt, 1);
    check("b2b_ready_gap", lg_rdy[FLEN], 1'b1);
    check("b2b_start_next", lg_txd[FLEN+1], 1'b0);
    check("b2b_f1_bit0", lg_txd[CPB+2], 1'b0);
    check("b2b_f1_bit7", lg_txd[8*CPB+2], 1'b0);
    check("b2b_f2_bit0", lg_txd[FLEN+1+CPB+2], 1'b1);
    check("b2b_f2_bit7", lg_txd[FLEN+1+8*CPB+2], 1'b1);

    // Reset on cycle 13 of a frame
    tx_valid = 1'b1; tx_data = 8'h00;
    step();
    tx_valid = 1'b0;
    repeat (12) step();
    check("pre_abort_txd", TxD, 1'b0);
    reset = 1'b1;
    #1;
    check("abort_txd", TxD, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", tx_ready, 1'b0);
    step();
    reset = 1'b0;
    step();
    check("abort_ready_rise", tx_ready, 1'b1);
    repeat (3) step();

    // Clean frame after the abort
    tx_valid = 1'b1; tx_data = 8'h3C; lg_n = 0;
    step();
    tx_valid = 1'b0;
    repeat (FLEN + 2) step();
    for (int k = 0; k < NBITS; k++)
      check($sformatf("x3c_bit%0d", k), lg_txd[k*CPB+2], exp_3c[k]);
    cnt = 0;
    for (int i = 0; i < FLEN + 3; i++) cnt += int'(lg_busy[i]);
    check_int("x3c_frame_len", cnt, FLEN);

    // 5 data bits, 2 stop bits: 0x1F
    v5 = 1'b1; d5 = 5'h1F; lg_n = 0;
    step();
    v5 = 1'b0;
    repeat (F5LEN + 2) step();
    cnt = 0;
    for (int i = 0; i < F5LEN + 3; i++) cnt += int'(lg_busy5[i]);
    check_int("s2_frame_len", cnt, (PB == 1) ? 36 : 32);
    cnt = 0;
    for (int k = 0; k < 8; k++) cnt += int'(lg_txd5[(6+PB)*CPB+k]);
    check_int("s2_stop_high_cycles", cnt, 8);
    check("s2_busy_last", lg_busy5[F5LEN-1], 1'b1);
    check("s2_busy_done", lg_busy5[F5LEN], 1'b0);
`ifdef UART_TX_PARITY_EN
    check("s2_odd_parity_1f", lg_txd5[6*CPB+2], 1'b0);
    v5 = 1'b1; d5 = 5'h07; lg_n = 0;
    step();
    v5 = 1'b0;
    repeat (F5LEN + 2) step();
    check("p07_odd_bit", lg_txd5[6*CPB+2], 1'b0);
`endif

    // Default CLKS_PER_BIT start bit length
    check("def_idle_txd", txdd, 1'b1);
    vd = 1'b1; dd = 8'h55;
    step();
    vd = 1'b0;
    lowc = 0;
    while (txdd == 1'b0 && lowc < 20000) begin
      lowc++;
      step();
    end
    check_int("def_start_len", lowc, 10416);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 10416, clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL provide parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL provide parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-004 SHALL provide parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity; used only when UART_TX_PARITY_EN is defined.
REQ-005 clk  input  1  single clock for the whole block; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 tx_valid  input  1  a word is offered on tx_data.
REQ-008 tx_data  input  DATA_BITS  word to transmit, LSB first.
REQ-009 tx_ready  output  1  block can accept a word this cycle.
REQ-010 TxD  output  1  serial line; idle high; registered, glitch-free.
REQ-011 busy  output  1  high from the cycle after acceptance until the frame's last stop-bit cycle completes.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE: tx_ready=1, busy=0, TxD=1; on tx_valid&&tx_ready, latch tx_data into the shift register, clear the baud and bit counters, and enter START on the next edge.
REQ-014 tx_ready SHALL be 0 in all states other than IDLE; tx_valid and tx_data SHALL be ignored while tx_ready=0.
REQ-015 START: TxD=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-016 DATA: TxD = shift register bit 0; shift right every CLKS_PER_BIT cycles; after DATA_BITS bits, go to PARITY (if compiled in) or STOP.
REQ-017 PARITY: TxD = XOR of the latched word, inverted when PARITY_ODD=1; lasts CLKS_PER_BIT cycles, then go to STOP.
REQ-018 STOP: TxD=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
REQ-019 Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary, with no off-by-one (each bit is exactly CLKS_PER_BIT cycles).
REQ-020 Bit counter SHALL be wide enough to count DATA_BITS and SHALL clear on every state entry.
REQ-021 Frame length from acceptance edge to return to IDLE SHALL be (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity, else 0.
REQ-022 Back-to-back transfers: with tx_valid held high, tx_ready SHALL be high for exactly one cycle between frames; the next start bit follows immediately, with no additional idle bit time.
REQ-023 The latched word SHALL be immune to tx_data changes after acceptance.

Reset
REQ-024 On reset assertion, asynchronously and regardless of state: state=IDLE, TxD=1, tx_ready=0, busy=0, counters=0, shift register=0.
REQ-025 tx_ready SHALL rise on the first clk edge after reset deasserts.
REQ-026 Reset mid-frame SHALL abort the frame; TxD returns high immediately, with no further line activity.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, the PARITY state and parity bit are compiled in; when undefined, PARITY is absent, DATA goes directly to STOP, and PARITY_ODD has no effect.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-028 Reset, no parity, DATA_BITS=8: send 0xA5 -> TxD = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; frame = 40 cycles; tx_ready=0 throughout.
REQ-029 UART_TX_PARITY_EN, PARITY_ODD=0: send 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame = 44 cycles.
REQ-030 STOP_BITS=2, DATA_BITS=5: send 0x1F -> TxD high for 8 cycles after the data bits; frame = 32 cycles.
REQ-031 tx_valid held high, words 0x00 then 0xFF -> exactly 1 cycle with tx_ready=1 between frames; tx_data changed mid-frame does not alter TxD.
REQ-032 Assert reset at cycle 13 of a frame -> TxD=1 in the same cycle, busy=0, tx_ready=1 one edge after release; the next send of 0x3C is a clean frame.
REQ-033 Default CLKS_PER_BIT=10416: start bit low for exactly 10416 cycles.
